// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner.
// Drives one-hot active-low columns, samples pulled-up rows through a two-flop
// synchronizer, debounces press and release, and reports a 4-bit key code
// {row, col} with a valid level and single-cycle press/release pulses.
// Optional feature: define KEYPAD_REPEAT_EN to enable auto-repeat press pulses
// while a key is held (REPEAT_DELAY / REPEAT_RATE, both in ticks).
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DB_COUNT     = 4,
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] kb_row,
  output logic [3:0] kb_column,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_press,
  output logic       key_release
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DbW  = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;

  localparam logic [1:0] StScan     = 2'd0;
  localparam logic [1:0] StDebounce = 2'd1;
  localparam logic [1:0] StHeld     = 2'd2;
  localparam logic [1:0] StRelease  = 2'd3;

  // Reject configurations the scan/debounce logic cannot honour.
  if (SCAN_DIV < 2 || DB_COUNT < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
    $error("keypad_scanner: invalid parameter configuration");
  end

  logic [3:0]      row_meta_q, row_sync_q;
  logic [CntW-1:0] cnt_q;
  logic            tick;
  logic            any_low;
  logic [1:0]      low_idx;

  logic [1:0]      state_q, state_d;
  logic [1:0]      col_q, col_d;
  logic [DbW-1:0]  db_cnt_q, db_cnt_d;
  logic [3:0]      cand_q, cand_d;
  logic [3:0]      key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
  logic            key_press_q, key_press_d;
  logic            key_release_q, key_release_d;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RptW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
  logic [RptW-1:0] rpt_cnt_q, rpt_cnt_d, rpt_next;
`endif

  // Two-flop synchronizer for the asynchronous row inputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= kb_row;
      row_sync_q <= row_meta_q;
    end
  end

  // Column dwell counter; tick marks the last cycle of each dwell
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick    = (cnt_q == CntW'(SCAN_DIV - 1));
  assign any_low = (row_sync_q != 4'hF);

  // Lowest-index low row wins when several rows are closed
  always_comb begin
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_sync_q[i]) low_idx = i[1:0];
    end
  end

  // Scan / debounce state machine; all decisions are taken on tick
  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    db_cnt_d      = db_cnt_q;
    cand_d        = cand_q;
    key_code_d    = key_code_q;
    key_valid_d   = key_valid_q;
    key_press_d   = 1'b0;
    key_release_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rpt_cnt_d     = rpt_cnt_q;
    rpt_next      = rpt_cnt_q + 1'b1;
`endif
    if (tick) begin
      case (state_q)
        StScan: begin
          if (any_low) begin
            cand_d   = {low_idx, col_q};
            db_cnt_d = '0;
            state_d  = StDebounce;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        StDebounce: begin
          if (any_low && (low_idx == cand_q[3:2])) begin
            if (db_cnt_q == DbW'(DB_COUNT - 1)) begin
              state_d     = StHeld;
              db_cnt_d    = '0;
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
              key_press_d = 1'b1;
`ifdef KEYPAD_REPEAT_EN
              rpt_cnt_d   = '0;
`endif
            end else begin
              db_cnt_d = db_cnt_q + 1'b1;
            end
          end else begin
            // Bounce or different row: give up and move on without reporting
            state_d  = StScan;
            db_cnt_d = '0;
            col_d    = col_q + 2'd1;
          end
        end
        StHeld: begin
          if (!any_low) begin
            state_d  = StRelease;
            db_cnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt_d = '0;
`endif
          end else begin
`ifdef KEYPAD_REPEAT_EN
            // Counter parks at REPEAT_DELAY after each repeat so later repeats
            // are spaced by REPEAT_RATE.
            if (rpt_next == RptW'(REPEAT_DELAY + REPEAT_RATE)) begin
              key_press_d = 1'b1;
              rpt_cnt_d   = RptW'(REPEAT_DELAY);
            end else begin
              if (rpt_next == RptW'(REPEAT_DELAY)) key_press_d = 1'b1;
              rpt_cnt_d = rpt_next;
            end
`endif
          end
        end
        StRelease: begin
          if (!any_low) begin
            if (db_cnt_q == DbW'(DB_COUNT - 1)) begin
              state_d       = StScan;
              db_cnt_d      = '0;
              key_valid_d   = 1'b0;
              key_release_d = 1'b1;
              col_d         = col_q + 2'd1;
            end else begin
              db_cnt_d = db_cnt_q + 1'b1;
            end
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt_d = '0;
`endif
          end else begin
            state_d  = StHeld;
            db_cnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt_d = '0;
`endif
          end
        end
        default: begin
          state_d = StScan;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StScan;
      col_q         <= 2'd0;
      db_cnt_q      <= '0;
      cand_q        <= 4'h0;
      key_code_q    <= 4'h0;
      key_valid_q   <= 1'b0;
      key_press_q   <= 1'b0;
      key_release_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      db_cnt_q      <= db_cnt_d;
      cand_q        <= cand_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt_q     <= rpt_cnt_d;
`endif
    end
  end

  assign kb_column   = ~(4'b0001 << col_q);
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_press   = key_press_q;
  assign key_release = key_release_q;

endmodule
